// File: rtl/xor_fold_sched_if.sv
// Word-in / result-out valid/ready bundle for xor_fold_sched.
// The slave modport is the folding block. The master modport is the producer and consumer side.
interface xor_fold_sched_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/xor_fold_sched.sv
// Sequential XOR fold of up to MAX_WORDS words through a single WIDTH-bit XOR.
// Define XOR_FOLD_SCHED_ABORT_EN to add the abort_i input, which drops the frame in flight.
//
// state | meaning
// IDLE  | waiting for start_i; len_i is sampled together with start_i
// ACCUM | accepting words and folding each one into acc_q
// DONE  | holding the result on out_data until out_ready
module xor_fold_sched #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 8,
  parameter int LEN_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
`ifdef XOR_FOLD_SCHED_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             busy_o,
  output logic [LEN_W-1:0] count_o,
  xor_fold_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  state_t           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [LEN_W-1:0] rem_q;
  logic             busy_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  logic [LEN_W-1:0] len_clamp_d;
  logic [WIDTH-1:0] acc_d;
  logic             abort_w;

`ifdef XOR_FOLD_SCHED_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  assign len_clamp_d = (len_i > MAX_LEN) ? MAX_LEN : len_i;
  assign acc_d       = acc_q ^ bus.in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            acc_q  <= '0;
            rem_q  <= len_clamp_d;
            busy_q <= 1'b1;
            if (len_clamp_d != '0) begin
              state_q    <= ACCUM;
              in_ready_q <= 1'b1;
            end else begin
              // An empty frame still produces a result, which is zero.
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= '0;
            end
          end
        end
        ACCUM: begin
          if (abort_w) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
          end else if (bus.in_valid) begin
            acc_q <= acc_d;
            rem_q <= rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= acc_d;
            end
          end
        end
        DONE: begin
          if (abort_w || bus.out_ready) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            if (abort_w) begin
              acc_q <= '0;
              rem_q <= '0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // rem_q is non-zero only in ACCUM, so it can drive COUNT directly.
  assign count_o       = rem_q;
  assign busy_o        = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_xor_fold_sched.sv
// Directed bench for xor_fold_sched. Define XOR_FOLD_SCHED_ABORT_EN to also exercise abort.
module tb_xor_fold_sched;
  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             busy;
  logic [LEN_W-1:0] count;

  int total;
  int bad;

  xor_fold_sched_if #(.WIDTH(WIDTH)) bus ();

  xor_fold_sched #(.WIDTH(WIDTH), .MAX_WORDS(8), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .len_i   (len),
`ifdef XOR_FOLD_SCHED_ABORT_EN
    .abort_i (abort),
`endif
    .busy_o  (busy),
    .count_o (count),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h want=00", bus.out_data); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_fold8();
    bus.out_ready = 1'b1;
    start = 1'b1; len = 4'd8;
    step();
    start = 1'b0;
    total++; if (count !== 4'd8) begin bad++; $display("FAIL fold8_count0 got=%0d want=8", count); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL fold8_in_ready got=%b want=1", bus.in_ready); end
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 8'(1 << i);
      step();
      if (i < 7) begin
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fold8_early_valid word=%0d got=%b want=0", i, bus.out_valid); end
      end
    end
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL fold8_out_valid got=%b want=1", bus.out_valid); end
    total++; if (bus.out_data !== 8'hFF) begin bad++; $display("FAIL fold8_out_data got=%h want=ff", bus.out_data); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fold8_busy_after got=%b want=0", busy); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fold8_valid_after got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] dat [5];
    logic       vld [5];
    logic [3:0] cnt [5];
    dat = '{8'hA5, 8'h00, 8'h5A, 8'h00, 8'hFF};
    vld = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    cnt = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
    bus.out_ready = 1'b0;
    start = 1'b1; len = 4'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = vld[i]; bus.in_data = dat[i];
      step();
      total++; if (count !== cnt[i]) begin bad++; $display("FAIL bp_count cyc=%0d got=%0d want=%0d", i, count, cnt[i]); end
    end
    bus.in_valid = 1'b0;
    // A5 ^ 5A = FF, then FF ^ FF = 00.
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00) begin
        bad++; $display("FAIL bp_hold cyc=%0d got valid=%b data=%h want valid=1 data=00", i, bus.out_valid, bus.out_data);
      end
      if (i < 3) step();
    end
    bus.out_ready = 1'b1;
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_len0();
    start = 1'b1; len = 4'd0;
    step();
    start = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00) begin
      bad++; $display("FAIL len0_result got valid=%b data=%h want valid=1 data=00", bus.out_valid, bus.out_data);
    end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL len0_in_ready got=%b want=0", bus.in_ready); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL len0_idle got=%b want=0", busy); end
  endtask

  task automatic test_len15();
    start = 1'b1; len = 4'd15;
    step();
    start = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if (count !== 4'(8 - i)) begin bad++; $display("FAIL len15_count word=%0d got=%0d want=%0d", i, count, 8 - i); end
      bus.in_data = 8'(i + 1);
      step();
    end
    bus.in_valid = 1'b0;
    // 1^2^3^4^5^6^7^8 = 08
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h08) begin
      bad++; $display("FAIL len15_result got valid=%b data=%h want valid=1 data=08", bus.out_valid, bus.out_data);
    end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL len15_count_done got=%0d want=0", count); end
    step();
  endtask

  task automatic test_len1();
    start = 1'b1; len = 4'd1;
    step();
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h3C;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) begin
      bad++; $display("FAIL len1_result got valid=%b data=%h want valid=1 data=3c", bus.out_valid, bus.out_data);
    end
    step();
  endtask

  task automatic test_start_ignored();
    bus.out_ready = 1'b0;
    start = 1'b1; len = 4'd2;
    step();
    len = 4'd5;
    bus.in_valid = 1'b1; bus.in_data = 8'h0F;
    step();
    total++; if (count !== 4'd1) begin bad++; $display("FAIL sti_count got=%0d want=1", count); end
    start = 1'b0;
    bus.in_data = 8'hF0;
    step();
    bus.in_valid = 1'b0;
    start = 1'b1;
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hFF) begin
      bad++; $display("FAIL sti_done got valid=%b data=%h want valid=1 data=ff", bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b1;
    step();
    start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sti_idle got=%b want=0", busy); end
    step();
    total++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL sti_no_restart got busy=%b in_ready=%b want 0 0", busy, bus.in_ready);
    end
  endtask

  task automatic test_reset_midframe();
    start = 1'b1; len = 4'd5;
    step();
    start = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'(8'h10 + i);
      step();
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || count !== 4'd0) begin
      bad++; $display("FAIL rst_async got busy=%b in_ready=%b out_valid=%b count=%0d want 0 0 0 0",
                      busy, bus.in_ready, bus.out_valid, count);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    start = 1'b1; len = 4'd2;
    step();
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h11;
    step();
    bus.in_data = 8'h22;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h33) begin
      bad++; $display("FAIL rst_fresh got valid=%b data=%h want valid=1 data=33", bus.out_valid, bus.out_data);
    end
    step();
  endtask

`ifdef XOR_FOLD_SCHED_ABORT_EN
  task automatic test_abort();
    bus.out_ready = 1'b1;
    start = 1'b1; len = 4'd4;
    step();
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h81;
    step();
    bus.in_data = 8'h42; abort = 1'b1;
    step();
    bus.in_valid = 1'b0;
    total++; if (busy !== 1'b0 || bus.out_valid !== 1'b0 || count !== 4'd0) begin
      bad++; $display("FAIL abort_idle got busy=%b out_valid=%b count=%0d want 0 0 0", busy, bus.out_valid, count);
    end
    // Abort held high in IDLE must not block this start.
    start = 1'b1; len = 4'd1;
    step();
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_restart got=%b want=1", busy); end
    bus.in_valid = 1'b1; bus.in_data = 8'h77;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h77) begin
      bad++; $display("FAIL abort_cleared got valid=%b data=%h want valid=1 data=77", bus.out_valid, bus.out_data);
    end
    step();
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fold8();
    test_backpressure();
    test_len0();
    test_len15();
    test_len1();
    test_start_ignored();
    test_reset_midframe();
`ifdef XOR_FOLD_SCHED_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
